addrreg_burst_ctrl: RTL and testbench

//  Sequencer/arbiter for two addrreg channels (ch0 = program counter, ch1 = data pointer) sharing one address bus.

---
 rtl/addrreg_burst_ctrl.sv | 122 ++++++++++++
 tb/tb_addrreg_burst_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addrreg_burst_ctrl.sv
// Sequencer/arbiter for two addrreg channels sharing one address bus.
// Handles channel loads, arbitration and post-incrementing bursts against a strobe/ready handshake.
module addrreg_burst_ctrl #(
    parameter int unsigned LEN_WIDTH = 4,
    parameter bit          FAIR      = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [1:0]           LD,
    input  logic [1:0]           REQ,
    input  logic [LEN_WIDTH-1:0] LEN0,
    input  logic [LEN_WIDTH-1:0] LEN1,
    input  logic                 MEM_RDY,
    output logic [1:0]           LOAD_bar,
    output logic [1:0]           INC,
    output logic [1:0]           ASSERT_bar,
    output logic [1:0]           GNT,
    output logic                 MEM_STB,
    output logic [1:0]           DONE,
    output logic                 BUSY
);

    typedef enum logic [1:0] {StIdle, StLoad, StXfer, StGap} state_e;

    state_e               state_q, state_d;
    logic                 sel_q, sel_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic                 req_win;
    logic [1:0]           sel_oh;

    // Round-robin only matters when both request; a sole requester always wins.
    always_comb begin
        if (FAIR && (&REQ)) begin
            req_win = ~last_q;
        end else begin
            req_win = ~REQ[0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (|LD) begin
                    sel_d   = ~LD[0];
                    state_d = StLoad;
                end else if (|REQ) begin
                    sel_d   = req_win;
                    cnt_d   = req_win ? LEN1 : LEN0;
                    state_d = StXfer;
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            StXfer: begin
                if (MEM_RDY) begin
                    if (cnt_q == '0) begin
                        state_d = StGap;
                    end else begin
                        cnt_d = cnt_q - LEN_WIDTH'(1);
                    end
                end
            end
            StGap: begin
                last_d  = sel_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign sel_oh = sel_q ? 2'b10 : 2'b01;

    // INC is the only Mealy output: the pointer advances on the edge the word completes.
    always_comb begin
        LOAD_bar   = 2'b11;
        ASSERT_bar = 2'b11;
        INC        = 2'b00;
        GNT        = 2'b00;
        MEM_STB    = 1'b0;
        DONE       = 2'b00;
        BUSY       = (state_q != StIdle);
        unique case (state_q)
            StLoad: begin
                LOAD_bar = ~sel_oh;
            end
            StXfer: begin
                ASSERT_bar = ~sel_oh;
                GNT        = sel_oh;
                MEM_STB    = 1'b1;
                INC        = MEM_RDY ? sel_oh : 2'b00;
            end
            StGap: begin
                DONE = sel_oh;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_addrreg_burst_ctrl.sv
// Self-checking bench for addrreg_burst_ctrl with behavioural addrreg pointer models.
// Expectations come from the burst/arbitration rules, not from the controller's internals.
module tb_addrreg_burst_ctrl;

    localparam int LW = 4;
    localparam logic [11:0] IDLE_OUT = 12'b11_11_00_00_0_00_0;

    logic          CLK = 1'b0;
    logic          RST;
    logic [1:0]    LD, REQ;
    logic [LW-1:0] LEN0, LEN1;
    logic          MEM_RDY;

    logic [1:0] LOAD_bar, INC, ASSERT_bar, GNT, DONE;
    logic       MEM_STB, BUSY;
    logic [1:0] LOAD_bar_fp, INC_fp, ASSERT_bar_fp, GNT_fp, DONE_fp;
    logic       MEM_STB_fp, BUSY_fp;

    logic [15:0] ptr [2];
    logic [15:0] bus_in;
    bit          last_ref;
    int          n_checks = 0;
    int          n_errors = 0;

    addrreg_burst_ctrl #(.LEN_WIDTH(LW), .FAIR(1'b1)) dut (
        .CLK(CLK), .RST(RST), .LD(LD), .REQ(REQ), .LEN0(LEN0), .LEN1(LEN1),
        .MEM_RDY(MEM_RDY), .LOAD_bar(LOAD_bar), .INC(INC), .ASSERT_bar(ASSERT_bar),
        .GNT(GNT), .MEM_STB(MEM_STB), .DONE(DONE), .BUSY(BUSY)
    );

    addrreg_burst_ctrl #(.LEN_WIDTH(LW), .FAIR(1'b0)) dut_fp (
        .CLK(CLK), .RST(RST), .LD(LD), .REQ(REQ), .LEN0(LEN0), .LEN1(LEN1),
        .MEM_RDY(MEM_RDY), .LOAD_bar(LOAD_bar_fp), .INC(INC_fp), .ASSERT_bar(ASSERT_bar_fp),
        .GNT(GNT_fp), .MEM_STB(MEM_STB_fp), .DONE(DONE_fp), .BUSY(BUSY_fp)
    );

    always #5 CLK = ~CLK;

    // Two addrreg pointers driven by the fair controller.
    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!LOAD_bar[i]) ptr[i] <= bus_in;
            else if (INC[i]) ptr[i] <= ptr[i] + 16'd1;
        end
    end

    function automatic logic [1:0] oh(input int ch);
        return (ch != 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [15:0] bus_addr();
        if (ASSERT_bar == 2'b10) return ptr[0];
        if (ASSERT_bar == 2'b01) return ptr[1];
        return 16'hxxxx;
    endfunction

    task automatic do_reset();
        RST = 1'b1; LD = 2'b00; REQ = 2'b00; MEM_RDY = 1'b0;
        @(negedge CLK); #1;
        RST = 1'b0;
        last_ref = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ = 2'b11; LD = 2'b11; MEM_RDY = 1'b1; LEN0 = '0; LEN1 = '0;
        bus_in = 16'h0000;
        repeat (4) begin
            @(negedge CLK); #1;
            n_checks++;
            if ({LOAD_bar, ASSERT_bar, INC, GNT, MEM_STB, DONE, BUSY} !== IDLE_OUT) begin
                n_errors++;
                $display("FAIL reset_outputs: got %b expected %b",
                         {LOAD_bar, ASSERT_bar, INC, GNT, MEM_STB, DONE, BUSY}, IDLE_OUT);
            end
            n_checks++;
            if ({LOAD_bar_fp, ASSERT_bar_fp, INC_fp, GNT_fp, MEM_STB_fp, DONE_fp, BUSY_fp}
                !== IDLE_OUT) begin
                n_errors++;
                $display("FAIL reset_outputs_fp: got %b expected %b",
                         {LOAD_bar_fp, ASSERT_bar_fp, INC_fp, GNT_fp, MEM_STB_fp, DONE_fp,
                          BUSY_fp}, IDLE_OUT);
            end
        end
        LD = 2'b00; REQ = 2'b00; MEM_RDY = 1'b0;
        RST = 1'b0;
        last_ref = 1'b1;
        @(negedge CLK); #1;
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_idle: got BUSY=%b expected 0", BUSY);
        end
    endtask

    // LD pattern wins over any REQ; the lowest set LD bit selects the channel.
    task automatic test_load(input logic [1:0] ld_pat, input logic [1:0] req_pat,
                             input logic [15:0] val);
        int ch;
        ch = ld_pat[0] ? 0 : 1;
        bus_in = val; LD = ld_pat; REQ = req_pat;
        @(negedge CLK); #1;
        n_checks++;
        if ({LOAD_bar, ASSERT_bar, GNT, BUSY} !== {~oh(ch), 2'b11, 2'b00, 1'b1}) begin
            n_errors++;
            $display("FAIL load_cycle: got LOAD_bar=%b ASSERT_bar=%b GNT=%b BUSY=%b expected %b 11 00 1",
                     LOAD_bar, ASSERT_bar, GNT, BUSY, ~oh(ch));
        end
        LD = 2'b00; REQ = 2'b00;
        @(negedge CLK); #1;
        n_checks++;
        if ({LOAD_bar, BUSY} !== {2'b11, 1'b0}) begin
            n_errors++;
            $display("FAIL load_one_cycle: got LOAD_bar=%b BUSY=%b expected 11 0", LOAD_bar, BUSY);
        end
        n_checks++;
        if (ptr[ch] !== val) begin
            n_errors++;
            $display("FAIL load_value ch%0d: got %h expected %h", ch, ptr[ch], val);
        end
    endtask

    // One burst of len+1 words. wait_max: wait states per word (fixed or random up to it).
    // noise scrambles REQ/LD/LEN mid-burst, which must be ignored.
    task automatic test_burst(input int ch, input int len, input int wait_max, input bit fixed,
                              input bit noise, input bit keep_req);
        logic [15:0] start;
        int          words;
        int          waits_left;
        start = ptr[ch];
        REQ = oh(ch);
        if (ch != 0) LEN1 = LW'(len); else LEN0 = LW'(len);
        MEM_RDY = 1'b0;
        words = 0;
        waits_left = fixed ? wait_max : $urandom_range(wait_max, 0);
        while (words <= len) begin
            @(negedge CLK);
            MEM_RDY = (waits_left == 0);
            if (noise) begin
                REQ = 2'($urandom); LD = 2'($urandom);
                LEN0 = LW'($urandom); LEN1 = LW'($urandom);
            end
            #1;
            n_checks++;
            if ({GNT, ASSERT_bar, MEM_STB, BUSY, LOAD_bar, DONE} !==
                {oh(ch), ~oh(ch), 1'b1, 1'b1, 2'b11, 2'b00}) begin
                n_errors++;
                $display("FAIL xfer_outputs ch%0d word%0d: got GNT=%b ASSERT_bar=%b STB=%b BUSY=%b LOAD_bar=%b DONE=%b",
                         ch, words, GNT, ASSERT_bar, MEM_STB, BUSY, LOAD_bar, DONE);
            end
            n_checks++;
            if (INC !== (MEM_RDY ? oh(ch) : 2'b00)) begin
                n_errors++;
                $display("FAIL xfer_inc ch%0d word%0d: got %b expected %b", ch, words, INC,
                         MEM_RDY ? oh(ch) : 2'b00);
            end
            n_checks++;
            if (bus_addr() !== start + 16'(words)) begin
                n_errors++;
                $display("FAIL xfer_addr ch%0d word%0d: got %h expected %h", ch, words,
                         bus_addr(), start + 16'(words));
            end
            if (MEM_RDY) begin
                words++;
                waits_left = fixed ? wait_max : $urandom_range(wait_max, 0);
            end else begin
                waits_left--;
            end
        end
        @(negedge CLK);
        MEM_RDY = 1'($urandom);
        LD = 2'b00;
        REQ = keep_req ? oh(ch) : 2'b00;
        #1;
        n_checks++;
        if ({DONE, GNT, ASSERT_bar, MEM_STB, BUSY, INC} !==
            {oh(ch), 2'b00, 2'b11, 1'b0, 1'b1, 2'b00}) begin
            n_errors++;
            $display("FAIL gap_outputs ch%0d: got DONE=%b GNT=%b ASSERT_bar=%b STB=%b BUSY=%b INC=%b",
                     ch, DONE, GNT, ASSERT_bar, MEM_STB, BUSY, INC);
        end
        last_ref = (ch != 0);
        n_checks++;
        if (ptr[ch] !== start + 16'(len + 1)) begin
            n_errors++;
            $display("FAIL burst_end_ptr ch%0d: got %h expected %h", ch, ptr[ch],
                     start + 16'(len + 1));
        end
        MEM_RDY = 1'b0;
        @(negedge CLK); #1;
        n_checks++;
        if ({BUSY, DONE, GNT, INC} !== 7'b0) begin
            n_errors++;
            $display("FAIL post_gap_idle ch%0d: got BUSY=%b DONE=%b GNT=%b INC=%b", ch, BUSY,
                     DONE, GNT, INC);
        end
    endtask

    task automatic test_back_to_back();
        test_burst(0, 1, 0, 1'b1, 1'b0, 1'b1);
        test_burst(0, 2, 0, 1'b1, 1'b0, 1'b1);
        test_burst(0, 0, 1, 1'b0, 1'b0, 1'b0);
    endtask

    // Both channels hold REQ with LEN=0: XFER, GAP, IDLE repeating.
    task automatic test_fair();
        int exp_ch;
        do_reset();
        REQ = 2'b11; LEN0 = '0; LEN1 = '0; MEM_RDY = 1'b1;
        exp_ch = last_ref ? 0 : 1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge CLK); #1;
            if (cyc == 11) REQ = 2'b00;
            n_checks++;
            case (cyc % 3)
                0: begin
                    if ({GNT, GNT_fp, MEM_STB} !== {oh(exp_ch), 2'b01, 1'b1}) begin
                        n_errors++;
                        $display("FAIL arb_grant cyc%0d: got GNT=%b GNT_fp=%b STB=%b expected %b 01 1",
                                 cyc, GNT, GNT_fp, MEM_STB, oh(exp_ch));
                    end
                end
                1: begin
                    if ({DONE, DONE_fp, GNT} !== {oh(exp_ch), 2'b01, 2'b00}) begin
                        n_errors++;
                        $display("FAIL arb_done cyc%0d: got DONE=%b DONE_fp=%b GNT=%b expected %b 01 00",
                                 cyc, DONE, DONE_fp, GNT, oh(exp_ch));
                    end
                    last_ref = (exp_ch != 0);
                    exp_ch = 1 - exp_ch;
                end
                default: begin
                    if ({BUSY, BUSY_fp, GNT, GNT_fp} !== 6'b0) begin
                        n_errors++;
                        $display("FAIL arb_idle cyc%0d: got BUSY=%b BUSY_fp=%b GNT=%b GNT_fp=%b",
                                 cyc, BUSY, BUSY_fp, GNT, GNT_fp);
                    end
                end
            endcase
        end
        MEM_RDY = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] start;
        start = ptr[0];
        REQ = 2'b01; LEN0 = LW'(3); MEM_RDY = 1'b1;
        @(negedge CLK); #1;
        n_checks++;
        if (GNT !== 2'b01 || bus_addr() !== start) begin
            n_errors++;
            $display("FAIL midrst_word0: got GNT=%b addr=%h expected 01 %h", GNT, bus_addr(), start);
        end
        @(negedge CLK); #1;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({LOAD_bar, ASSERT_bar, INC, GNT, MEM_STB, DONE, BUSY} !== IDLE_OUT) begin
            n_errors++;
            $display("FAIL midrst_async: got %b expected %b",
                     {LOAD_bar, ASSERT_bar, INC, GNT, MEM_STB, DONE, BUSY}, IDLE_OUT);
        end
        REQ = 2'b10;
        repeat (2) begin
            @(negedge CLK); #1;
            n_checks++;
            if ({DONE, BUSY, GNT} !== 5'b0) begin
                n_errors++;
                $display("FAIL midrst_no_done: got DONE=%b BUSY=%b GNT=%b expected 00 0 00",
                         DONE, BUSY, GNT);
            end
        end
        n_checks++;
        if (ptr[0] !== start + 16'd1) begin
            n_errors++;
            $display("FAIL midrst_ptr0: got %h expected %h", ptr[0], start + 16'd1);
        end
        RST = 1'b0;
        last_ref = 1'b1;
        test_burst(1, 2, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int ch;
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(3, 0) == 0) begin
                test_load(2'($urandom_range(3, 1)), 2'($urandom), 16'($urandom));
            end
            ch = $urandom_range(1, 0);
            test_burst(ch, $urandom_range(15, 0), $urandom_range(3, 0), 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        LD = 2'b00; REQ = 2'b00; MEM_RDY = 1'b0; LEN0 = '0; LEN1 = '0;
        test_reset();
        test_load(2'b01, 2'b00, 16'h1234);
        test_burst(0, 3, 0, 1'b1, 1'b0, 1'b0);
        test_load(2'b01, 2'b00, 16'h1234);
        test_burst(0, 3, 2, 1'b1, 1'b0, 1'b0);
        test_load(2'b11, 2'b11, 16'h0100);
        test_load(2'b10, 2'b01, 16'hFFFE);
        test_burst(1, 3, 1, 1'b0, 1'b0, 1'b0);
        test_burst(0, 0, 0, 1'b1, 1'b0, 1'b0);
        test_burst(1, 15, 1, 1'b0, 1'b1, 1'b0);
        test_back_to_back();
        test_fair();
        test_load(2'b01, 2'b00, 16'h2000);
        test_load(2'b10, 2'b00, 16'h3000);
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
